// File: rtl/reg_slice_vr_s.sv
// Valid/ready register slice with a two-entry skid buffer.
// Every output is decoded from flops, so neither handshake direction has a combinational path.
`ifndef REG_DELAY_CYCLE
`define REG_DELAY_CYCLE
`endif

module reg_slice_vr_s #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready,
  output logic [1:0]            o_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic                  in_fire, out_fire;
  logic                  load_main_in, load_main_skid, load_skid;

  // The state encoding doubles as the held-beat count.
  assign o_in_ready  = (state_q != FULL);
  assign o_out_valid = (state_q != EMPTY);
  assign o_out_data  = main_q;
  assign o_count     = state_q;

  assign in_fire  = i_in_valid & o_in_ready;
  assign out_fire = o_out_valid & i_out_ready;

  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          load_main_in = 1'b1;
          state_d      = ONE;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          load_main_in = 1'b1;
        end else if (in_fire) begin
          load_skid = 1'b1;
          state_d   = FULL;
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          load_main_skid = 1'b1;
          state_d        = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Flush only collapses the state; data registers keep whatever they loaded.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= i_flush ? EMPTY : state_d;
      if (load_main_in) begin
        main_q <= `REG_DELAY_CYCLE i_in_data;
      end else if (load_main_skid) begin
        main_q <= `REG_DELAY_CYCLE skid_q;
      end
      if (load_skid) begin
        skid_q <= `REG_DELAY_CYCLE i_in_data;
      end
    end
  end

`ifdef REG_CHECK
  reg_chk #(.WIDTH(DATA_WIDTH)) u_chk_in (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (i_in_valid),
    .i_data (i_in_data)
  );

  reg_chk #(.WIDTH(DATA_WIDTH)) u_chk_out (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_en   (o_out_valid),
    .i_data (o_out_data)
  );
`endif

endmodule

// File: tb/tb_reg_slice_vr_s.sv
// Scenario bench for reg_slice_vr_s; a negedge monitor keeps a queue of accepted beats
// and checks each delivered beat against it in order.
module tb_reg_slice_vr_s;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [1:0]    count;

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  logic [DW-1:0] sb_q[$];

  reg_slice_vr_s #(.DATA_WIDTH(DW)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_flush    (flush),
    .i_in_valid (in_valid),
    .i_in_data  (in_data),
    .o_in_ready (in_ready),
    .o_out_valid(out_valid),
    .o_out_data (out_data),
    .i_out_ready(out_ready),
    .o_count    (count)
  );

  always #5 clk = ~clk;

  // Inputs change at posedge+1, so at negedge they describe the coming edge.
  always @(negedge clk) begin
    logic [DW-1:0] exp_d;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_beat: got %h with no beat pending", out_data);
      end else begin
        exp_d = sb_q.pop_front();
        delivered++;
        if (out_data !== exp_d) begin
          errors++;
          $display("[TB] FAIL order: got %h expected %h", out_data, exp_d);
        end
      end
    end
    if (!rst_n || flush) sb_q.delete();
    else if (in_valid && in_ready === 1'b1) sb_q.push_back(in_data);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 2'd0 || out_data !== '0) begin
      errors++;
      $display("[TB] FAIL reset: got v=%b r=%b c=%0d d=%h expected v=0 r=1 c=0 d=0",
               out_valid, in_ready, count, out_data);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = DW'(i);
      step();
      checks++;
      if (out_data !== DW'(i) || out_valid !== 1'b1 || count !== 2'd1 || in_ready !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stream_%0d: got d=%h v=%b c=%0d r=%b expected d=%h v=1 c=1 r=1",
                 i, out_data, out_valid, count, in_ready, DW'(i));
      end
    end
    in_valid = 1'b0;
    step();
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL stream_drain: got v=%b c=%0d expected v=0 c=0", out_valid, count);
    end
  endtask

  task automatic test_backpressure();
    int base;
    base      = delivered;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hA;
    step();
    in_data = 32'hB;
    step();
    in_data = 32'hC;
    step();
    checks++;
    if (count !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'hA) begin
      errors++;
      $display("[TB] FAIL bp_full: got c=%0d r=%b d=%h expected c=2 r=0 d=a", count, in_ready, out_data);
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_data !== 32'hB || count !== 2'd1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_release: got d=%h c=%0d r=%b expected d=b c=1 r=1", out_data, count, in_ready);
    end
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'hC || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL bp_last: got d=%h v=%b expected d=c v=1", out_data, out_valid);
    end
    step();
    checks++;
    if (delivered - base != 3 || count !== 2'd0) begin
      errors++;
      $display("[TB] FAIL bp_delivered: got %0d beats c=%0d expected 3 beats c=0", delivered - base, count);
    end
  endtask

  task automatic test_random();
    int   sent;
    int   cycles;
    logic r_before;
    sent   = 0;
    cycles = 0;
    while (sent < 1000 && cycles < 20000) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_data   = 32'h1000 + DW'(sent);
      out_ready = 1'($urandom_range(0, 1));
      r_before  = in_ready;
      #1 out_ready = ~out_ready;
      #1;
      checks++;
      if (in_ready !== r_before || count > 2'd2) begin
        errors++;
        $display("[TB] FAIL rand_ready_path: got r=%b c=%0d expected r=%b c<=2", in_ready, count, r_before);
      end
      out_ready = ~out_ready;
      if (in_valid && in_ready) sent++;
      @(posedge clk);
      #1;
      cycles++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycles    = 0;
    while (out_valid === 1'b1 && cycles < 10) begin
      step();
      cycles++;
    end
    checks++;
    if (sent != 1000 || sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rand_done: got sent=%0d pending=%0d expected sent=1000 pending=0",
               sent, sb_q.size());
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h11;
    step();
    in_data = 32'h22;
    step();
    in_valid = 1'b0;
    flush    = 1'b1;
    step();
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush: got v=%b c=%0d r=%b expected v=0 c=0 r=1", out_valid, count, in_ready);
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h33;
    step();
    in_valid = 1'b0;
    checks++;
    if (out_data !== 32'h33 || out_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL flush_next: got d=%h v=%b expected d=33 v=1", out_data, out_valid);
    end
    step();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h44;
    step();
    in_data = 32'h55;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || count !== 2'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid: got v=%b d=%h c=%0d r=%b expected v=0 d=0 c=0 r=1",
               out_valid, out_data, count, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL reset_quiet_%0d: got v=%b expected v=0", i, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [DW-1:0] held;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h66;
    step();
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0) ? 1'b0 : 1'b1;
      in_data  = 32'h70 + DW'(i);
      step();
      checks++;
      if (out_data !== 32'h66 || held !== 32'h66 || out_valid !== 1'b1) begin
        errors++;
        $display("[TB] FAIL stall_%0d: got d=%h v=%b expected d=66 v=1", i, out_data, out_valid);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    step();
    checks++;
    if (sb_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL stall_drain: got pending=%0d v=%b expected pending=0 v=0", sb_q.size(), out_valid);
    end
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_flush();
    test_reset_mid();
    test_stall();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
